// File: rtl/imem_load_sequencer_if.sv
// Byte-stream handshake carrying the program image into the load sequencer.
// A byte moves when valid and ready are both high at a rising clock edge.
interface imem_load_sequencer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/imem_load_sequencer.sv
// Boot/run sequencer: loads a length-prefixed byte stream into instruction memory, then runs the core.
// Build option IMEM_LOAD_CHECKSUM_EN appends and verifies an XOR checksum byte after the payload.
module imem_load_sequencer #(
  parameter int DEPTH      = 1024,
  parameter int RUN_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  imem_load_sequencer_if.slave        rx,
  output logic                        imem_wr_en,
  output logic [31:0]                 imem_wr_addr,
  output logic [31:0]                 imem_wr_data,
  output logic                        cpu_start,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    LOAD,
    LAST_WR,
`ifdef IMEM_LOAD_CHECKSUM_EN
    CHECK,
`endif
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic             ready_q;
  logic [7:0]       cnt_lo;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift_q;
  logic [RUN_W-1:0] run_cnt;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic             accept;
  logic [CNT_W-1:0] hdr;

  assign rx.ready = ready_q;
  assign accept   = rx.valid & ready_q;
  assign hdr      = {rx.data, cnt_lo};

  // NOTE: every register here is a small flop, so all of them sit in the async reset;
  // non-blocking assignments keep each edge reading the pre-edge values consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      cnt_lo       <= '0;
      n_words      <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      shift_q      <= '0;
      run_cnt      <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum         <= '0;
`endif
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_start    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          ready_q  <= 1'b1;
          busy     <= 1'b0;
          word_idx <= '0;
          byte_cnt <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum     <= '0;
`endif
          if (accept) begin
            cnt_lo <= rx.data;
            busy   <= 1'b1;
            state  <= CNT_HI;
          end
        end

        CNT_HI: begin
          if (accept) begin
            n_words <= hdr;
            if (hdr == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              state   <= CHECK;
`else
              ready_q <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
`endif
            end else if (32'(hdr) > DEPTH) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            shift_q  <= {rx.data, shift_q[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum ^ rx.data;
`endif
            if (byte_cnt == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= 32'({word_idx, 2'b00});
              imem_wr_data <= {rx.data, shift_q};
              word_idx     <= word_idx + 1'b1;
              // Stop taking bytes while the final word is being written.
              if (word_idx == n_words - 1'b1) begin
                ready_q <= 1'b0;
                state   <= LAST_WR;
              end
            end
          end
        end

        LAST_WR: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          ready_q   <= 1'b1;
          state     <= CHECK;
`else
          cpu_start <= 1'b1;
          run_cnt   <= RUN_W'(RUN_CYCLES - 1);
          state     <= RUN;
`endif
        end

`ifdef IMEM_LOAD_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (rx.data != csum) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (n_words == '0) begin
              ready_q <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              ready_q   <= 1'b0;
              cpu_start <= 1'b1;
              run_cnt   <= RUN_W'(RUN_CYCLES - 1);
              state     <= RUN;
            end
          end
        end
`endif

        RUN: begin
          if (run_cnt == '0) begin
            cpu_start <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            run_cnt <= run_cnt - 1'b1;
          end
        end

        DONE: begin
          busy    <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          cpu_start <= 1'b0;
          busy      <= 1'b0;
          ready_q   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Scoreboard bench for imem_load_sequencer: stimulus queues expected writes/runs/pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_load_sequencer;

  localparam int DEPTH      = 1024;
  localparam int RUN_CYCLES = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_load_sequencer_if rx_if ();

  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        err;

  imem_load_sequencer #(
    .DEPTH      (DEPTH),
    .RUN_CYCLES (RUN_CYCLES),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_if),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  typedef enum int {EV_WR, EV_RUN, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  logic [31:0] prog[$];
  int n_cmp = 0;
  int n_bad = 0;

  // RUN payload d = {ready seen during run, rise directly after a write}
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [31:0] RUN_FLAGS = 32'd0;
`else
  localparam logic [31:0] RUN_FLAGS = 32'd1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  function automatic void push_ev(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endfunction

  task automatic take(input ev_kind_t k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d a=0x%08h d=0x%08h, want none", int'(k), a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (e.kind == EV_WR && k == EV_WR) begin
        check("wr_addr", a, e.a);
        check("wr_data", d, e.d);
      end else if (e.kind == EV_RUN && k == EV_RUN) begin
        check("run_len", a, e.a);
        check("run_flags", d, e.d);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int   run_len  = 0;
  bit   prev_wr  = 0;
  bit   rise_ok  = 0;
  bit   rdy_run  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      prev_wr = 0;
      rise_ok = 0;
      rdy_run = 0;
    end else begin
      if (imem_wr_en) take(EV_WR, imem_wr_addr, imem_wr_data);
      if (cpu_start) begin
        if (run_len == 0) begin
          rise_ok = prev_wr;
          rdy_run = 0;
        end
        run_len++;
        if (rx_if.ready) rdy_run = 1;
      end else if (run_len != 0) begin
        take(EV_RUN, 32'(run_len), {30'd0, rdy_run, rise_ok});
        run_len = 0;
      end
      if (done) take(EV_DONE, 32'd0, 32'd0);
      if (err)  take(EV_ERR, 32'd0, 32'd0);
      prev_wr = imem_wr_en;
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    budget = RUN_CYCLES + 100;
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) begin
        rx_if.valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_if.data  = b;
    rx_if.valid = 1'b1;
    while (!rx_if.ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      check("send_timeout", 32'(budget), 32'(1));
    end else begin
      @(posedge clk); #1;
    end
    rx_if.valid = 1'b0;
  endtask

  task automatic send_prog(input bit gaps, input bit bad_csum, input bit push_tail);
    logic [7:0] cs;
    logic [7:0] by;
    int n;
    cs = 8'h00;
    n  = prog.size();
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    for (int i = 0; i < n; i++) begin
      push_ev(EV_WR, 32'(i * 4), prog[i]);
      for (int b = 0; b < 4; b++) begin
        by = prog[i][8*b +: 8];
        cs = cs ^ by;
        send_byte(by, gaps);
      end
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, gaps);
    if (push_tail) begin
      if (bad_csum) begin
        push_ev(EV_ERR, 32'd0, 32'd0);
      end else begin
        if (n != 0) push_ev(EV_RUN, 32'(RUN_CYCLES), RUN_FLAGS);
        push_ev(EV_DONE, 32'd0, 32'd0);
      end
    end
`else
    if (push_tail) begin
      if (n != 0) push_ev(EV_RUN, 32'(RUN_CYCLES), RUN_FLAGS);
      push_ev(EV_DONE, 32'd0, 32'd0);
    end
`endif
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < RUN_CYCLES + 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_outs_zero"}, 32'({imem_wr_en, cpu_start, busy, done, err, rx_if.ready}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check({name, "_ready_held"}, 32'(rx_if.ready), 32'd0);
    @(posedge clk); #1;
    check({name, "_ready_up"}, 32'(rx_if.ready), 32'd1);
  endtask

  task automatic load_test1_prog();
    prog.delete();
    prog.push_back(32'h00A00513);
    prog.push_back(32'h0000006F);
  endtask

  initial begin
    int k;
    rx_if.data  = 8'h00;
    rx_if.valid = 1'b0;

    // Reset state
    #1;
    check("reset_outs_zero", 32'({imem_wr_en, cpu_start, busy, done, err, rx_if.ready}), 32'd0);
    check("reset_addr_data", imem_wr_addr | imem_wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("reset_ready_held", 32'(rx_if.ready), 32'd0);
    @(posedge clk); #1;
    check("reset_ready_up", 32'(rx_if.ready), 32'd1);

    // Two-word program, one byte per cycle
    load_test1_prog();
    send_prog(1'b0, 1'b0, 1'b1);
    wait_idle("prog_b2b");

    // Empty program
    prog.delete();
    send_prog(1'b0, 1'b0, 1'b1);
    wait_idle("empty");

    // Header above DEPTH is rejected, then a one-word load
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    push_ev(EV_ERR, 32'd0, 32'd0);
    wait_idle("reject");
    prog.delete();
    prog.push_back(32'h00100093);
    send_prog(1'b0, 1'b0, 1'b1);
    wait_idle("after_reject");

    // Header exactly DEPTH is accepted and starts a load
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("depth_busy_ready", 32'({busy, rx_if.ready}), 32'b11);
    pulse_reset("rst_depth");

    // Random valid gaps
    load_test1_prog();
    send_prog(1'b1, 1'b0, 1'b1);
    wait_idle("prog_gaps");

    // Reset after the third payload byte
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    pulse_reset("rst_load");
    check("rst_load_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the run window
    load_test1_prog();
    send_prog(1'b0, 1'b0, 1'b0);
    k = 0;
    while (!cpu_start && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_run_started", 32'(cpu_start), 32'd1);
    repeat (RUN_CYCLES / 2) @(posedge clk);
    #1;
    pulse_reset("rst_run");
    check("rst_run_queue", 32'(exp_q.size()), 32'd0);

    // Reload from address 0
    load_test1_prog();
    send_prog(1'b0, 1'b0, 1'b1);
    wait_idle("reload");

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Corrupted checksum: words written, no run
    load_test1_prog();
    send_prog(1'b0, 1'b1, 1'b1);
    wait_idle("bad_csum");
`endif

    repeat (5) @(posedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
